// File: rtl/mapper_flit_receiver.sv
// mapper_flit_receiver: NoC ejection-port receiver for a mapper.
// Flits addressed to this port are queued in a show-ahead FIFO.
// Every flit that is consumed or misrouted returns one credit upstream.
// A small FSM tracks packet boundaries, and a counter counts delivered packets.
module mapper_flit_receiver #(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int DEST_BITS       = 2,
    parameter int VC_BITS         = 1,
    parameter int MY_PORT         = 0,
    parameter int FIFO_DEPTH      = 8,
    parameter int FLIT_W          = 2 + FLIT_DATA_WIDTH + DEST_BITS + VC_BITS
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [FLIT_W-1:0]          flit_in,
    output logic [VC_BITS:0]           credit_out,
    output logic [FLIT_DATA_WIDTH-1:0] data_out,
    output logic                       data_tail,
    output logic                       data_valid,
    input  logic                       data_ready,
    output logic                       in_packet,
    output logic [15:0]                pkt_count,
    output logic                       overflow_err,
    output logic                       dest_err
);
    localparam int ENT_W    = 1 + VC_BITS + FLIT_DATA_WIDTH;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    // The credit queue holds at least FIFO_DEPTH+2 entries. It is a power of 2, so the pointers wrap without extra logic.
    localparam int CQ_DEPTH = 2 * FIFO_DEPTH;
    localparam int CQ_PTR_W = $clog2(CQ_DEPTH);
    localparam int PEND_W   = $clog2(CQ_DEPTH + 1);

    typedef enum logic {IDLE, IN_PKT} state_t;

    // Fields of the incoming flit, packed MSB first as {valid, tail, dest, vc, data}.
    logic                       w_valid, w_tail;
    logic [DEST_BITS-1:0]       w_dest;
    logic [VC_BITS-1:0]         w_vc;
    logic [FLIT_DATA_WIDTH-1:0] w_data;
    assign w_valid = flit_in[FLIT_W-1];
    assign w_tail  = flit_in[FLIT_W-2];
    assign w_dest  = flit_in[FLIT_W-3 -: DEST_BITS];
    assign w_vc    = flit_in[FLIT_DATA_WIDTH +: VC_BITS];
    assign w_data  = flit_in[FLIT_DATA_WIDTH-1:0];

    // Flit FIFO storage and pointers
    logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [ENT_W-1:0] w_head;
    logic [VC_BITS-1:0] w_head_vc;
    logic w_full, w_pop, w_arrive, w_mine, w_write, w_drop, w_misroute;

    // Set during reset and for the first edge after it, so that edge ignores flit_in.
    logic r_rst_q;

    assign w_head     = r_mem[r_rptr];
    assign data_tail  = w_head[ENT_W-1];
    assign w_head_vc  = w_head[FLIT_DATA_WIDTH +: VC_BITS];
    assign data_out   = w_head[FLIT_DATA_WIDTH-1:0];
    assign data_valid = (r_count != '0);
    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop      = data_valid & data_ready;
    assign w_arrive   = w_valid & ~r_rst_q;
    assign w_mine     = (w_dest == DEST_BITS'(MY_PORT));
    // A full FIFO can still take a flit when the head leaves in the same cycle.
    assign w_write    = w_arrive & w_mine & (~w_full | w_pop);
    assign w_drop     = w_arrive & w_mine & w_full & ~w_pop;
    assign w_misroute = w_arrive & ~w_mine;

    // Credit scheduling: the pop credit is queued ahead of the misroute credit.
    logic [1:0]          w_n_inc;
    logic [VC_BITS-1:0]  w_new0, w_new1, w_emit_vc;
    logic                w_emit;
    logic [VC_BITS-1:0]  r_cq [CQ_DEPTH];
    logic [CQ_PTR_W-1:0] r_cq_wptr, r_cq_rptr;
    logic [PEND_W-1:0]   r_pend;
    logic [VC_BITS:0]    r_credit;

    assign w_n_inc = {1'b0, w_pop} + {1'b0, w_misroute};
    assign w_new0  = w_pop ? w_head_vc : w_vc;
    assign w_new1  = w_vc;
    // When nothing is pending, the oldest new credit bypasses the queue. Credits then leave the cycle after they are scheduled.
    assign w_emit    = (r_pend != '0) | w_pop | w_misroute;
    assign w_emit_vc = (r_pend != '0) ? r_cq[r_cq_rptr] : w_new0;
    assign credit_out = r_credit;

    state_t r_state, w_state_next;
    logic [15:0] r_pkt_count;
    logic r_overflow_err, r_dest_err;

    assign in_packet    = (r_state == IN_PKT);
    assign pkt_count    = r_pkt_count;
    assign overflow_err = r_overflow_err;
    assign dest_err     = r_dest_err;

    // Payload storage. It has no reset because its contents are meaningless while the count is zero.
    always_ff @(posedge CLK) begin
        if (w_write) r_mem[r_wptr] <= {w_tail, w_vc, w_data};
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_write) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)   r_rptr <= r_rptr + PTR_W'(1);
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Credit vc queue storage. Up to two entries are pushed per cycle.
    always_ff @(posedge CLK) begin
        if (w_n_inc != 2'd0) r_cq[r_cq_wptr] <= w_new0;
        if (w_n_inc == 2'd2) r_cq[r_cq_wptr + CQ_PTR_W'(1)] <= w_new1;
    end

    // Pending-credit counter, queue pointers and registered credit output
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cq_wptr <= '0;
            r_cq_rptr <= '0;
            r_pend    <= '0;
            r_credit  <= '0;
        end else begin
            r_cq_wptr <= r_cq_wptr + CQ_PTR_W'(w_n_inc);
            r_cq_rptr <= r_cq_rptr + CQ_PTR_W'(w_emit);
            r_pend    <= r_pend + PEND_W'(w_n_inc) - PEND_W'(w_emit);
            r_credit  <= w_emit ? {1'b1, w_emit_vc} : '0;
        end
    end

    // Delivery FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Delivery FSM next state. A tail pop always ends the packet, and a non-tail pop opens one.
    always_comb begin
        w_state_next = r_state;
        if (w_pop) begin
            case (r_state)
                IDLE:    if (!data_tail) w_state_next = IN_PKT;
                IN_PKT:  if (data_tail)  w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Packet counter, sticky error flags and the post-reset arrival mask
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pkt_count    <= '0;
            r_overflow_err <= 1'b0;
            r_dest_err     <= 1'b0;
            r_rst_q        <= 1'b1;
        end else begin
            r_rst_q <= 1'b0;
            if (w_pop && data_tail) r_pkt_count <= r_pkt_count + 16'd1;
            if (w_drop)     r_overflow_err <= 1'b1;
            if (w_misroute) r_dest_err     <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mapper_flit_receiver.sv
// Directed testbench for mapper_flit_receiver with its default parameters.
module tb_mapper_flit_receiver;
    logic        CLK, RST;
    logic [36:0] flit_in;
    logic [1:0]  credit_out;
    logic [31:0] data_out;
    logic        data_tail, data_valid, data_ready, in_packet;
    logic [15:0] pkt_count;
    logic        overflow_err, dest_err;

    int n_tests = 0;
    int n_fail  = 0;

    mapper_flit_receiver dut (
        .CLK(CLK), .RST(RST), .flit_in(flit_in), .credit_out(credit_out),
        .data_out(data_out), .data_tail(data_tail), .data_valid(data_valid),
        .data_ready(data_ready), .in_packet(in_packet), .pkt_count(pkt_count),
        .overflow_err(overflow_err), .dest_err(dest_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [36:0] mk(input logic t, input logic [1:0] d,
                                       input logic vc, input logic [31:0] data);
        return {1'b1, t, d, vc, data};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) begin
            $display("[TB] check %s ok (0x%0h)", tag, obs);
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int errs;
        RST = 1'b1; flit_in = '0; data_ready = 1'b0;
        step(); step();
        chk("rst_valid",    data_valid, 0);
        chk("rst_inpkt",    in_packet, 0);
        chk("rst_pkt",      pkt_count, 0);
        chk("rst_credit",   credit_out, 0);
        chk("rst_ovf",      overflow_err, 0);
        chk("rst_dest",     dest_err, 0);

        // Test the flit that arrives on the edge right after RST deasserts. It must be ignored.
        RST = 1'b0;
        flit_in = mk(1, 0, 0, 32'h1111_1111);
        step();
        flit_in = '0;
        chk("rel_ignored", data_valid, 0);
        step();

        // Test a single-flit packet.
        data_ready = 1'b1;
        flit_in = mk(1, 0, 0, 32'hDEAD_BEEF);
        step();
        flit_in = '0;
        chk("single_valid",  data_valid, 1);
        chk("single_data",   data_out, 32'hDEAD_BEEF);
        chk("single_tail",   data_tail, 1);
        chk("single_nocred", credit_out, 0);
        step();
        chk("single_pkt",    pkt_count, 1);
        chk("single_credit", credit_out, 2'b10);
        chk("single_empty",  data_valid, 0);
        step();
        chk("single_cred_off", credit_out, 0);

        // Test backpressure with 9 flits into 8 entries. The 9th flit is dropped.
        data_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            flit_in = mk(1, 0, 0, 32'h100 + i);
            step();
            chk($sformatf("fill_nocred_%0d", i), credit_out, 0);
            if (i == 7) chk("fill_no_ovf_at_8", overflow_err, 0);
        end
        flit_in = '0;
        chk("full_ovf",  overflow_err, 1);
        chk("full_head", data_out, 32'h100);
        step();
        chk("full_hold_nocred", credit_out, 0);
        chk("full_hold_head", data_out, 32'h100);
        data_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_data_%0d", i), data_out, 32'h100 + i);
            step();
            chk($sformatf("drain_credit_%0d", i), credit_out, 2'b10);
        end
        chk("drain_empty", data_valid, 0);
        step();
        chk("drain_cred_off", credit_out, 0);
        chk("drain_pkt", pkt_count, 9);
        chk("ovf_sticky", overflow_err, 1);

        // Test a write that coincides with a pop while the FIFO is full.
        data_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            flit_in = mk(1, 0, 0, 32'h200 + i);
            step();
        end
        data_ready = 1'b1;
        flit_in = mk(1, 0, 0, 32'h208);
        step();
        flit_in = '0;
        chk("wp_credit", credit_out, 2'b10);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("wp_data_%0d", i), data_out, 32'h200 + i);
            step();
            chk($sformatf("wp_credit_%0d", i), credit_out, 2'b10);
        end
        chk("wp_empty", data_valid, 0);
        chk("wp_pkt", pkt_count, 18);
        step();

        // Test a misrouted flit that arrives in the same cycle as a pop.
        data_ready = 1'b0;
        flit_in = mk(1, 0, 0, 32'h300);
        step();
        chk("mis_nocred0", credit_out, 0);
        data_ready = 1'b1;
        flit_in = mk(0, 1, 1, 32'h333);
        step();
        flit_in = '0;
        chk("mis_dest_err", dest_err, 1);
        chk("mis_not_written", data_valid, 0);
        chk("mis_credit1", credit_out, 2'b10);
        step();
        chk("mis_credit2", credit_out, 2'b11);
        step();
        chk("mis_cred_off", credit_out, 0);
        chk("mis_pkt", pkt_count, 19);

        // Test a 4-flit packet streamed with data_ready held high.
        flit_in = mk(0, 0, 0, 32'h400);
        step();
        chk("mf_idle0", in_packet, 0);
        flit_in = mk(0, 0, 0, 32'h401);
        step();
        chk("mf_inpkt1", in_packet, 1);
        chk("mf_data1", data_out, 32'h401);
        flit_in = mk(0, 0, 0, 32'h402);
        step();
        chk("mf_inpkt2", in_packet, 1);
        flit_in = mk(1, 0, 0, 32'h403);
        step();
        chk("mf_inpkt3", in_packet, 1);
        chk("mf_tail3", {data_tail, data_out}, {1'b1, 32'h403});
        chk("mf_pkt_mid", pkt_count, 19);
        flit_in = '0;
        step();
        chk("mf_idle_end", in_packet, 0);
        chk("mf_pkt", pkt_count, 20);
        step();

        // Test reset in the middle of a packet while a credit is still pending.
        data_ready = 1'b0;
        flit_in = mk(0, 0, 0, 32'h500);
        step();
        flit_in = mk(0, 0, 0, 32'h501);
        step();
        data_ready = 1'b1;
        flit_in = mk(0, 2, 1, 32'h555);
        step();
        flit_in = '0; data_ready = 1'b0;
        chk("rm_inpkt", in_packet, 1);
        chk("rm_credit", credit_out, 2'b10);
        RST = 1'b1;
        #1;
        chk("rm_valid", data_valid, 0);
        chk("rm_inpkt0", in_packet, 0);
        chk("rm_pkt0", pkt_count, 0);
        chk("rm_credit0", credit_out, 0);
        chk("rm_dest0", dest_err, 0);
        step();
        RST = 1'b0;
        step();
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            if (credit_out !== 2'b00 || data_valid !== 1'b0) errs++;
            step();
        end
        chk("rm_no_stale_credit", errs, 0);
        data_ready = 1'b1;
        flit_in = mk(1, 0, 0, 32'h600);
        step();
        flit_in = '0;
        chk("rm_new_data", data_out, 32'h600);
        step();
        chk("rm_new_pkt", pkt_count, 1);
        chk("rm_new_credit", credit_out, 2'b10);

        // Test pkt_count wrap: 65536 streamed single-flit packets after a fresh reset.
        RST = 1'b1;
        step();
        RST = 1'b0;
        step();
        errs = 0;
        for (int j = 0; j < 65536; j++) begin
            flit_in = mk(1, 0, 0, j);
            step();
            if (data_valid !== 1'b1 || data_out !== 32'(j)) errs++;
        end
        flit_in = '0;
        chk("wrap_stream_order", errs, 0);
        chk("wrap_pkt_ffff", pkt_count, 16'hFFFF);
        step();
        chk("wrap_pkt_zero", pkt_count, 16'h0000);
        chk("wrap_empty", data_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
